esm_dep_matrix: RTL and testbench
=================================

ESM_DEP_MATRIX -- requirements
Module: esm_dep_matrix

Interface
REQ-001 SHALL have parameter INSTR_W, default 32, meaning instruction word width.
REQ-002 SHALL have parameter NREG, default 32, meaning architectural register count (5-bit fields at [19:15], [24:20], [11:7]).
REQ-003 SHALL have parameter BS, default 16, meaning window depth in slots; SLOT_W = $clog2(BS).
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-005 SHALL have ports: alloc_valid in 1; alloc_ready out 1; instr in INSTR_W; uses_rs2 in 1; writes_rd in 1; alloc_idx out SLOT_W (slot receiving the accepted instruction).
REQ-006 SHALL have ports: issue_valid out 1; issue_idx out SLOT_W; issue_ack in 1.
REQ-007 SHALL have ports: cmpl_valid in 1; cmpl_idx in SLOT_W; cmpl_err out 1 (sticky).
REQ-008 SHALL have ports: full out 1; empty out 1; occupancy out SLOT_W+1.

Function
REQ-009 Each slot SHALL hold state FREE, WAIT or ISSUED, plus a BS-bit dependency row and a BS-bit age row.
REQ-010 Allocation SHALL occur on alloc_valid && alloc_ready; target is the lowest-index FREE slot, driven combinationally on alloc_idx; slot becomes WAIT next edge.
REQ-011 Dependency row at allocation SHALL set bit j iff slot j is the valid in-flight producer of rs1, or of rs2 when uses_rs2=1; register 0 never creates a dependency.
REQ-012 Age row at allocation SHALL equal the set of non-FREE slots (all older).
REQ-013 Producer table SHALL map each register to {valid, slot}; allocation with writes_rd=1 and rd!=0 SHALL overwrite the entry for rd.
REQ-014 Completion (cmpl_valid, slot ISSUED) SHALL clear column cmpl_idx in every dependency row, invalidate producer entries still pointing to cmpl_idx, and set the slot FREE, all at the next edge.
REQ-015 Same-edge allocation writing register r and completion invalidating r SHALL leave the new allocation as producer of r.
REQ-016 Completion of a slot not ISSUED SHALL be ignored and set cmpl_err until reset.
REQ-017 issue_valid SHALL be high iff some WAIT slot has an all-zero dependency row; issue_idx SHALL be the oldest such slot (no other ready slot marked older in its age row).
REQ-018 issue_ack with issue_valid SHALL move issue_idx to ISSUED next edge; issue_ack without issue_valid SHALL be ignored.
REQ-019 Latency: an independent instruction SHALL raise issue_valid the cycle after allocation; a dependent SHALL become issuable the cycle after its last producer's completion.
REQ-020 full SHALL be high when no slot is FREE; empty when all are FREE; occupancy = non-FREE count; a slot freed by completion SHALL be allocatable only from the next cycle.

Reset
REQ-021 On rst all slots SHALL be FREE, dependency and age rows zero, producer table invalid, cmpl_err 0.
REQ-022 During/after reset outputs SHALL be: alloc_ready 1, issue_valid 0, full 0, empty 1, occupancy 0; reset mid-operation SHALL discard all in-flight slots.

Configuration
REQ-023 With ESM_DEP_BYPASS_EN defined, alloc_ready SHALL equal !full and a same-cycle completing producer SHALL be masked out of the new dependency row and producer lookup.
REQ-024 Without ESM_DEP_BYPASS_EN, alloc_ready SHALL equal !full && !cmpl_valid (allocation stalls during any completion cycle).

Structure
REQ-025 Package esm_pkg SHALL hold slot-state enum, register-field bit positions and default parameter constants.
REQ-026 Producer table SHALL be sub-module esm_prod_table (lookup two sources, update one dest, invalidate by slot).

Verification (BS=4)
REQ-027 Reset, allocate addi x1 (rd=1) -> alloc_idx 0, next cycle issue_valid=1, issue_idx=0, occupancy 1.
REQ-028 Allocate x1 writer (slot 0) then add x2,x1,x1 (slot 1), ack slot 0 -> slot 1 not issuable; complete 0 -> issue_idx=1 one cycle later.
REQ-029 Allocate four independent instructions -> full=1, alloc_ready=0; complete slot 2 after ack -> full=0 next cycle, next alloc_idx=2, and it is youngest (slots 0,1,3 issue first).
REQ-030 Slots 3 (older) and 1 both ready -> issue_idx=3 before 1.
REQ-031 cmpl_valid on a WAIT slot -> cmpl_err=1, state unchanged; rst clears cmpl_err.
REQ-032 Allocation reading x1 in same cycle as x1 producer completes -> with ESM_DEP_BYPASS_EN issuable next cycle; without, alloc_ready=0 that cycle.

Source files
------------

// File: rtl/esm_pkg.sv
// Shared types and constants for the dependency-matrix scheduler window.
// Register field positions follow the RV32 R/I-type layout.
package esm_pkg;

  typedef enum logic [1:0] {
    SLOT_FREE   = 2'd0,
    SLOT_WAIT   = 2'd1,
    SLOT_ISSUED = 2'd2
  } slot_state_e;

  localparam int REG_FIELD_W = 5;
  localparam int RD_LSB      = 7;
  localparam int RS1_LSB     = 15;
  localparam int RS2_LSB     = 20;

  localparam int DEF_INSTR_W = 32;
  localparam int DEF_NREG    = 32;
  localparam int DEF_BS      = 16;

  typedef struct packed {
    logic [REG_FIELD_W-1:0] rd;
    logic [REG_FIELD_W-1:0] rs1;
    logic [REG_FIELD_W-1:0] rs2;
  } reg_fields_t;

endpackage

// File: rtl/esm_prod_table.sv
// Register -> in-flight producer slot map: two combinational lookups, one write per cycle,
// and invalidate-by-slot on completion; a same-edge write wins over the invalidate.
module esm_prod_table
  import esm_pkg::*;
#(
  parameter int  NREG   = DEF_NREG,
  parameter int  BS     = DEF_BS,
  localparam int SLOT_W = $clog2(BS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_FIELD_W-1:0] src1_reg,
  input  logic [REG_FIELD_W-1:0] src2_reg,
  output logic                   src1_vld,
  output logic [SLOT_W-1:0]      src1_slot,
  output logic                   src2_vld,
  output logic [SLOT_W-1:0]      src2_slot,
  input  logic                   wr_en,
  input  logic [REG_FIELD_W-1:0] wr_reg,
  input  logic [SLOT_W-1:0]      wr_slot,
  input  logic                   inv_en,
  input  logic [SLOT_W-1:0]      inv_slot
);

  logic [NREG-1:0]   prod_vld;
  logic [SLOT_W-1:0] prod_slot [NREG];

  always_comb begin
    src1_vld  = 1'b0;
    src1_slot = '0;
    src2_vld  = 1'b0;
    src2_slot = '0;
    for (int r = 0; r < NREG; r++) begin
      if (src1_reg == REG_FIELD_W'(r)) begin
        src1_vld  = prod_vld[r];
        src1_slot = prod_slot[r];
      end
      if (src2_reg == REG_FIELD_W'(r)) begin
        src2_vld  = prod_vld[r];
        src2_slot = prod_slot[r];
      end
    end
  end

  // x0 is hardwired, so its entry is never written and always reads invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_vld <= '0;
      for (int r = 0; r < NREG; r++) prod_slot[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (wr_en && (r != 0) && (wr_reg == REG_FIELD_W'(r))) begin
          prod_vld[r]  <= 1'b1;
          prod_slot[r] <= wr_slot;
        end else if (inv_en && prod_vld[r] && (prod_slot[r] == inv_slot)) begin
          prod_vld[r] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/esm_dep_matrix.sv
// Out-of-order issue window with dependency and age matrices; issue is visible the cycle after alloc/wakeup.
// alloc_ready drops when full (and on any completion cycle unless ESM_DEP_BYPASS_EN is defined).
module esm_dep_matrix
  import esm_pkg::*;
#(
  parameter int  INSTR_W = DEF_INSTR_W,
  parameter int  NREG    = DEF_NREG,
  parameter int  BS      = DEF_BS,
  localparam int SLOT_W  = $clog2(BS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_valid,
  output logic               alloc_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               uses_rs2,
  input  logic               writes_rd,
  output logic [SLOT_W-1:0]  alloc_idx,
  output logic               issue_valid,
  output logic [SLOT_W-1:0]  issue_idx,
  input  logic               issue_ack,
  input  logic               cmpl_valid,
  input  logic [SLOT_W-1:0]  cmpl_idx,
  output logic               cmpl_err,
  output logic               full,
  output logic               empty,
  output logic [SLOT_W:0]    occupancy
);

  localparam int CNT_W = SLOT_W + 1;

  slot_state_e       state [BS];
  logic [BS-1:0]     dep   [BS];
  logic [BS-1:0]     age   [BS];

  logic [BS-1:0]     free_mask;
  logic [BS-1:0]     ready_mask;
  logic [BS-1:0]     cmpl_col;
  logic [BS-1:0]     byp_mask;
  logic [BS-1:0]     new_dep;
  logic [BS-1:0]     new_age;
  logic              cmpl_fire;
  logic              alloc_fire;
  logic              issue_fire;
  reg_fields_t       fld;
  logic              src1_vld;
  logic              src2_vld;
  logic [SLOT_W-1:0] src1_slot;
  logic [SLOT_W-1:0] src2_slot;
  logic              unused_instr_bits;

  assign fld.rd  = instr[RD_LSB  +: REG_FIELD_W];
  assign fld.rs1 = instr[RS1_LSB +: REG_FIELD_W];
  assign fld.rs2 = instr[RS2_LSB +: REG_FIELD_W];
  assign unused_instr_bits = ^{instr[INSTR_W-1:RS2_LSB+REG_FIELD_W],
                               instr[RS1_LSB-1:RD_LSB+REG_FIELD_W], instr[RD_LSB-1:0]};

  always_comb begin
    free_mask  = '0;
    ready_mask = '0;
    for (int i = 0; i < BS; i++) begin
      free_mask[i]  = (state[i] == SLOT_FREE);
      ready_mask[i] = (state[i] == SLOT_WAIT) && (dep[i] == '0);
    end
  end

  assign full  = (free_mask == '0);
  assign empty = &free_mask;

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < BS; i++) begin
      if (!free_mask[i]) occupancy = occupancy + CNT_W'(1);
    end
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = BS - 1; i >= 0; i--) begin
      if (free_mask[i]) alloc_idx = SLOT_W'(i);
    end
  end

  // Oldest ready slot: no other ready slot appears in its age row.
  assign issue_valid = |ready_mask;
  always_comb begin
    issue_idx = '0;
    for (int i = BS - 1; i >= 0; i--) begin
      if (ready_mask[i] && ((age[i] & ready_mask) == '0)) issue_idx = SLOT_W'(i);
    end
  end

  assign cmpl_fire  = cmpl_valid && (state[cmpl_idx] == SLOT_ISSUED);
  assign cmpl_col   = cmpl_fire ? (BS'(1) << cmpl_idx) : '0;
  assign alloc_fire = alloc_valid && alloc_ready;
  assign issue_fire = issue_ack && issue_valid;

`ifdef ESM_DEP_BYPASS_EN
  assign alloc_ready = !full;
  assign byp_mask    = cmpl_col;
`else
  assign alloc_ready = !full && !cmpl_valid;
  assign byp_mask    = '0;
`endif

  always_comb begin
    new_dep = '0;
    if ((fld.rs1 != '0) && src1_vld)             new_dep[src1_slot] = 1'b1;
    if (uses_rs2 && (fld.rs2 != '0) && src2_vld) new_dep[src2_slot] = 1'b1;
    new_dep = new_dep & ~byp_mask;
  end

  assign new_age = ~free_mask & ~byp_mask;

  esm_prod_table #(
    .NREG (NREG),
    .BS   (BS)
  ) u_prod_table (
    .clk       (clk),
    .rst       (rst),
    .src1_reg  (fld.rs1),
    .src2_reg  (fld.rs2),
    .src1_vld  (src1_vld),
    .src1_slot (src1_slot),
    .src2_vld  (src2_vld),
    .src2_slot (src2_slot),
    .wr_en     (alloc_fire && writes_rd),
    .wr_reg    (fld.rd),
    .wr_slot   (alloc_idx),
    .inv_en    (cmpl_fire),
    .inv_slot  (cmpl_idx)
  );

  // Age columns are cleared on free too, so a recycled slot is never mistaken for an older one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmpl_err <= 1'b0;
      for (int i = 0; i < BS; i++) begin
        state[i] <= SLOT_FREE;
        dep[i]   <= '0;
        age[i]   <= '0;
      end
    end else begin
      if (cmpl_valid && !cmpl_fire) cmpl_err <= 1'b1;
      for (int i = 0; i < BS; i++) begin
        if (alloc_fire && (alloc_idx == SLOT_W'(i))) begin
          state[i] <= SLOT_WAIT;
          dep[i]   <= new_dep;
          age[i]   <= new_age;
        end else begin
          if (cmpl_fire && (cmpl_idx == SLOT_W'(i)))        state[i] <= SLOT_FREE;
          else if (issue_fire && (issue_idx == SLOT_W'(i))) state[i] <= SLOT_ISSUED;
          dep[i] <= dep[i] & ~cmpl_col;
          age[i] <= age[i] & ~cmpl_col;
        end
      end
    end
  end

endmodule

// File: tb/tb_esm_dep_matrix.sv
// Bench for esm_dep_matrix at BS=4: directed scenarios plus a randomized run against a sequence-number model.
module tb_esm_dep_matrix;

  localparam int BS = 4;
`ifdef ESM_DEP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid, alloc_ready, uses_rs2, writes_rd;
  logic [31:0] instr;
  logic [1:0]  alloc_idx, issue_idx, cmpl_idx;
  logic        issue_valid, issue_ack, cmpl_valid, cmpl_err, full, empty;
  logic [2:0]  occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  esm_dep_matrix #(.INSTR_W(32), .NREG(32), .BS(BS)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .instr(instr),
    .uses_rs2(uses_rs2), .writes_rd(writes_rd), .alloc_idx(alloc_idx),
    .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_ack(issue_ack),
    .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx), .cmpl_err(cmpl_err),
    .full(full), .empty(empty), .occupancy(occupancy)
  );

  function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
  endfunction

  task automatic set_in(input logic av, input logic [31:0] ins, input logic u2, input logic wr,
                        input logic ack, input logic cv, input logic [1:0] ci);
    alloc_valid = av; instr = ins; uses_rs2 = u2; writes_rd = wr;
    issue_ack = ack; cmpl_valid = cv; cmpl_idx = ci;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic do_reset();
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_async_empty got %b exp 1", empty); end
    n_cmp++;
    repeat (2) @(posedge clk);
    #1;
    if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL reset_alloc_ready got %b exp 1", alloc_ready); end
    n_cmp++;
    if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL reset_issue_valid got %b exp 0", issue_valid); end
    n_cmp++;
    if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b exp 0", full); end
    n_cmp++;
    if (occupancy !== 3'd0) begin n_bad++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
    n_cmp++;
    if (cmpl_err !== 1'b0) begin n_bad++; $display("FAIL reset_cmpl_err got %b exp 0", cmpl_err); end
    n_cmp++;
    rst = 1'b0;
  endtask

  task automatic test_independent();
    do_reset();
    set_in(1'b1, mk(1, 0, 0), 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    #1;
    if (alloc_idx !== 2'd0) begin n_bad++; $display("FAIL indep_alloc_idx got %0d exp 0", alloc_idx); end
    n_cmp++;
    tick();
    if (issue_valid !== 1'b1) begin n_bad++; $display("FAIL indep_issue_valid got %b exp 1", issue_valid); end
    n_cmp++;
    if (issue_idx !== 2'd0) begin n_bad++; $display("FAIL indep_issue_idx got %0d exp 0", issue_idx); end
    n_cmp++;
    if (occupancy !== 3'd1) begin n_bad++; $display("FAIL indep_occupancy got %0d exp 1", occupancy); end
    n_cmp++;
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0); tick();
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0); tick();
    if (empty !== 1'b1) begin n_bad++; $display("FAIL indep_empty_after got %b exp 1", empty); end
    n_cmp++;
  endtask

  task automatic test_dependency();
    do_reset();
    set_in(1'b1, mk(1, 0, 0), 1'b0, 1'b1, 1'b0, 1'b0, 2'd0); tick();
    set_in(1'b1, mk(2, 1, 1), 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    #1;
    if (alloc_idx !== 2'd1) begin n_bad++; $display("FAIL dep_alloc_idx got %0d exp 1", alloc_idx); end
    n_cmp++;
    tick();
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    #1;
    if (issue_idx !== 2'd0) begin n_bad++; $display("FAIL dep_first_issue got %0d exp 0", issue_idx); end
    n_cmp++;
    tick();
    if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL dep_blocked got %b exp 0", issue_valid); end
    n_cmp++;
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    #1;
    if (alloc_ready !== BYP) begin n_bad++; $display("FAIL dep_ready_in_cmpl got %b exp %b", alloc_ready, BYP); end
    n_cmp++;
    tick();
    if (issue_valid !== 1'b1 || issue_idx !== 2'd1) begin
      n_bad++; $display("FAIL dep_wakeup got v=%b idx=%0d exp v=1 idx=1", issue_valid, issue_idx);
    end
    n_cmp++;
  endtask

  task automatic test_full_age();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, mk(0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      #1;
      if (alloc_idx !== 2'(i)) begin n_bad++; $display("FAIL full_alloc_idx%0d got %0d", i, alloc_idx); end
      n_cmp++;
      tick();
    end
    if (full !== 1'b1 || alloc_ready !== 1'b0 || occupancy !== 3'd4) begin
      n_bad++; $display("FAIL full_flags got full=%b rdy=%b occ=%0d exp 1 0 4", full, alloc_ready, occupancy);
    end
    n_cmp++;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      #1;
      if (issue_idx !== 2'(i)) begin n_bad++; $display("FAIL full_issue_order%0d got %0d", i, issue_idx); end
      n_cmp++;
      tick();
    end
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    #1;
    if (full !== 1'b1) begin n_bad++; $display("FAIL full_during_cmpl got %b exp 1", full); end
    n_cmp++;
    tick();
    if (full !== 1'b0 || occupancy !== 3'd3) begin
      n_bad++; $display("FAIL full_after_cmpl got full=%b occ=%0d exp 0 3", full, occupancy);
    end
    n_cmp++;
    set_in(1'b1, mk(0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    #1;
    if (alloc_idx !== 2'd2) begin n_bad++; $display("FAIL full_realloc_idx got %0d exp 2", alloc_idx); end
    n_cmp++;
    tick();
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    #1;
    if (issue_idx !== 2'd3) begin n_bad++; $display("FAIL full_older_first got %0d exp 3", issue_idx); end
    n_cmp++;
    tick();
    if (issue_idx !== 2'd2) begin n_bad++; $display("FAIL full_youngest_last got %0d exp 2", issue_idx); end
    n_cmp++;
  endtask

  task automatic test_oldest_first();
    do_reset();
    repeat (4) begin set_in(1'b1, mk(0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0); tick(); end
    repeat (2) begin set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0); tick(); end
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1); tick();
    set_in(1'b1, mk(0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0); tick();
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    #1;
    if (issue_idx !== 2'd2) begin n_bad++; $display("FAIL old_first_2 got %0d exp 2", issue_idx); end
    n_cmp++;
    tick();
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    #1;
    if (issue_idx !== 2'd3) begin n_bad++; $display("FAIL old_3_before_1 got %0d exp 3", issue_idx); end
    n_cmp++;
    tick();
    if (issue_idx !== 2'd1 || issue_valid !== 1'b1) begin
      n_bad++; $display("FAIL old_last_1 got v=%b idx=%0d exp v=1 idx=1", issue_valid, issue_idx);
    end
    n_cmp++;
  endtask

  task automatic test_cmpl_err();
    do_reset();
    set_in(1'b1, mk(3, 0, 0), 1'b0, 1'b1, 1'b0, 1'b0, 2'd0); tick();
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0); tick();
    if (cmpl_err !== 1'b1) begin n_bad++; $display("FAIL err_set got %b exp 1", cmpl_err); end
    n_cmp++;
    if (issue_valid !== 1'b1 || issue_idx !== 2'd0 || occupancy !== 3'd1) begin
      n_bad++; $display("FAIL err_state_kept got v=%b idx=%0d occ=%0d exp 1 0 1", issue_valid, issue_idx, occupancy);
    end
    n_cmp++;
    rst = 1'b1;
    #1;
    if (cmpl_err !== 1'b0) begin n_bad++; $display("FAIL err_cleared got %b exp 0", cmpl_err); end
    n_cmp++;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_bypass();
    do_reset();
    set_in(1'b1, mk(1, 0, 0), 1'b0, 1'b1, 1'b0, 1'b0, 2'd0); tick();
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0); tick();
    set_in(1'b1, mk(2, 1, 0), 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    #1;
    if (alloc_ready !== BYP) begin n_bad++; $display("FAIL byp_ready got %b exp %b", alloc_ready, BYP); end
    n_cmp++;
    tick();
    if (issue_valid !== BYP) begin n_bad++; $display("FAIL byp_issue_valid got %b exp %b", issue_valid, BYP); end
    n_cmp++;
    if (occupancy !== {2'b00, BYP}) begin n_bad++; $display("FAIL byp_occupancy got %0d exp %0d", occupancy, BYP); end
    n_cmp++;
  endtask

  task automatic test_random();
    int          mst [BS];
    logic [3:0]  mdep [BS];
    int          mseq [BS];
    bit          pv [32];
    int          ps [32];
    bit          merr;
    int          seq_ctr, nfree, e_aidx, e_iidx, best, rd, rs1, rs2;
    bit          av, u2, wr, ack, cv, e_ardy, e_iv, fire_c;
    logic [1:0]  ci;
    logic [3:0]  ndep;
    int          iss [$];

    do_reset();
    for (int k = 0; k < BS; k++) begin mst[k] = 0; mdep[k] = '0; mseq[k] = 0; end
    for (int r = 0; r < 32; r++) begin pv[r] = 1'b0; ps[r] = 0; end
    merr = 1'b0;
    seq_ctr = 0;

    for (int cyc = 0; cyc < 800; cyc++) begin
      rd  = $urandom_range(0, 3);
      rs1 = $urandom_range(0, 3);
      rs2 = $urandom_range(0, 3);
      av  = ($urandom_range(0, 2) != 0);
      u2  = $urandom_range(0, 1);
      wr  = ($urandom_range(0, 3) != 0);
      ack = $urandom_range(0, 1);
      cv  = ($urandom_range(0, 2) == 0);
      iss.delete();
      for (int k = 0; k < BS; k++) if (mst[k] == 2) iss.push_back(k);
      if (iss.size() > 0 && $urandom_range(0, 15) != 0)
        ci = 2'(iss[$urandom_range(0, iss.size() - 1)]);
      else
        ci = 2'($urandom_range(0, 3));
      set_in(av, mk(rd, rs1, rs2), u2, wr, ack, cv, ci);
      #1;

      nfree = 0;
      e_aidx = -1;
      for (int k = BS - 1; k >= 0; k--) if (mst[k] == 0) begin nfree++; e_aidx = k; end
      e_ardy = (nfree > 0) && (BYP || !cv);
      e_iv = 1'b0;
      e_iidx = 0;
      best = -1;
      for (int k = 0; k < BS; k++) begin
        if (mst[k] == 1 && mdep[k] == '0 && (best < 0 || mseq[k] < best)) begin
          best = mseq[k]; e_iidx = k; e_iv = 1'b1;
        end
      end

      if (alloc_ready !== e_ardy) begin n_bad++; $display("FAIL rnd_alloc_ready cyc %0d got %b exp %b", cyc, alloc_ready, e_ardy); end
      n_cmp++;
      if (issue_valid !== e_iv) begin n_bad++; $display("FAIL rnd_issue_valid cyc %0d got %b exp %b", cyc, issue_valid, e_iv); end
      n_cmp++;
      if (e_iv) begin
        if (issue_idx !== 2'(e_iidx)) begin n_bad++; $display("FAIL rnd_issue_idx cyc %0d got %0d exp %0d", cyc, issue_idx, e_iidx); end
        n_cmp++;
      end
      if (nfree > 0) begin
        if (alloc_idx !== 2'(e_aidx)) begin n_bad++; $display("FAIL rnd_alloc_idx cyc %0d got %0d exp %0d", cyc, alloc_idx, e_aidx); end
        n_cmp++;
      end
      if (full !== (nfree == 0) || empty !== (nfree == BS) || occupancy !== 3'(BS - nfree)) begin
        n_bad++; $display("FAIL rnd_flags cyc %0d got full=%b empty=%b occ=%0d exp occ=%0d", cyc, full, empty, occupancy, BS - nfree);
      end
      n_cmp++;
      if (cmpl_err !== merr) begin n_bad++; $display("FAIL rnd_cmpl_err cyc %0d got %b exp %b", cyc, cmpl_err, merr); end
      n_cmp++;

      fire_c = cv && (mst[ci] == 2);
      if (cv && !fire_c) merr = 1'b1;
      ndep = '0;
      if (rs1 != 0 && pv[rs1] && !(BYP && fire_c && ps[rs1] == int'(ci))) ndep[ps[rs1]] = 1'b1;
      if (u2 && rs2 != 0 && pv[rs2] && !(BYP && fire_c && ps[rs2] == int'(ci))) ndep[ps[rs2]] = 1'b1;
      if (fire_c) begin
        mst[ci] = 0;
        for (int k = 0; k < BS; k++) mdep[k][ci] = 1'b0;
        for (int r = 0; r < 32; r++) if (pv[r] && ps[r] == int'(ci)) pv[r] = 1'b0;
      end
      if (ack && e_iv) mst[e_iidx] = 2;
      if (av && e_ardy) begin
        mst[e_aidx]  = 1;
        mdep[e_aidx] = ndep;
        mseq[e_aidx] = seq_ctr;
        seq_ctr++;
        if (wr && rd != 0) begin pv[rd] = 1'b1; ps[rd] = e_aidx; end
      end
      tick();
    end

    rst = 1'b1;
    #1;
    if (empty !== 1'b1 || occupancy !== 3'd0 || issue_valid !== 1'b0 || alloc_ready !== 1'b1) begin
      n_bad++; $display("FAIL rnd_midop_reset got empty=%b occ=%0d iv=%b rdy=%b", empty, occupancy, issue_valid, alloc_ready);
    end
    n_cmp++;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_independent();
    test_dependency();
    test_full_age();
    test_oldest_first();
    test_cmpl_err();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
